// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
// Pure definitions: no latency, no flow control.
package seg_scan_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int BANK_W     = MAX_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Digit i (i>0) is blanked when it and every higher digit read zero.
    function automatic logic [MAX_DIGITS-1:0] lzb_mask(
        input logic [BANK_W-1:0] bank,
        input int                num_digits
    );
        logic                  all_zero;
        logic [MAX_DIGITS-1:0] mask;
        all_zero = 1'b1;
        mask     = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero && (bank[i*DIGIT_W +: DIGIT_W] == '0);
                mask[i]  = (i > 0) && all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host write/commit inputs and decoder/digit-drive outputs of the scan controller.
// Plain wiring bundle: no latency, no flow control.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 2
);
    import seg_scan_pkg::*;

    logic                  i_disp_on;
    logic                  i_lzb_en;
    logic                  i_wr_en;
    logic [ADDR_W-1:0]     i_wr_addr;
    logic [DIGIT_W-1:0]    i_wr_data;
    logic                  i_commit;
    logic [DIGIT_W-1:0]    o_dec_a;
    logic                  o_dec_en;
    logic [NUM_DIGITS-1:0] o_dig_sel;
    logic                  o_frame_done;
    logic                  o_pending;

    modport slave (
        input  i_disp_on, i_lzb_en, i_wr_en, i_wr_addr, i_wr_data, i_commit,
        output o_dec_a, o_dec_en, o_dig_sel, o_frame_done, o_pending
    );

    modport master (
        output i_disp_on, i_lzb_en, i_wr_en, i_wr_addr, i_wr_data, i_commit,
        input  o_dec_a, o_dec_en, o_dig_sel, o_frame_done, o_pending
    );

endinterface

// File: rtl/seg_scan_timer.sv
// Phase counter: counts 0..i_last, flags terminal count, wraps; i_clr forces 0.
// Latency: o_tc is combinational from the count register; no backpressure.
module seg_scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_last,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered multiplexed seven-segment scanner with inter-digit blanking.
// Latency: all outputs registered from next-state decode; free-running, no backpressure.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 2,
    parameter int SHOW_CYC   = 50000,
    parameter int BLANK_CYC  = 8,
    parameter int CNT_W      = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    seg_scan_ctrl_if.slave  io_scan
);
    import seg_scan_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0]  SHOW_PRE   = CNT_W'(SHOW_CYC - 2);

    state_t                               r_state, w_state_nxt;
    logic [ADDR_W-1:0]                    r_idx, w_idx_nxt;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   r_shadow, r_display;
    logic                                 r_pending, r_frame_done, r_dec_en;
    logic [DIGIT_W-1:0]                   r_dec_a;
    logic [NUM_DIGITS-1:0]                r_dig_sel;

    logic [CNT_W-1:0]      w_cnt, w_last;
    logic                  w_tc, w_tmr_clr, w_fd_nxt, w_dec_en;
    logic [DIGIT_W-1:0]    w_dec_a;
    logic [NUM_DIGITS-1:0] w_dig_sel, w_lzb;

    assign w_last    = (r_state == SHOW) ? SHOW_LAST : BLANK_LAST;
    assign w_tmr_clr = (r_state == IDLE) || !io_scan.i_disp_on;
    assign w_lzb     = NUM_DIGITS'(lzb_mask(BANK_W'(r_display), NUM_DIGITS));

    seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_tmr_clr),
        .i_last (w_last),
        .o_cnt  (w_cnt),
        .o_tc   (w_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (!io_scan.i_disp_on) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_idx_nxt   = '0;
                end
                BLANK: begin
                    if (w_tc) w_state_nxt = SHOW;
                end
                SHOW: begin
                    if (w_tc) begin
                        w_state_nxt = BLANK;
                        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        w_dig_sel = '0;
        w_dec_a   = '0;
        w_dec_en  = 1'b0;
        if (w_state_nxt == SHOW) begin
            w_dig_sel = NUM_DIGITS'(1) << w_idx_nxt;
            w_dec_a   = r_display[w_idx_nxt];
            w_dec_en  = !(io_scan.i_lzb_en && w_lzb[w_idx_nxt]);
        end
        if (SHOW_CYC > 1) begin
            w_fd_nxt = io_scan.i_disp_on && (r_state == SHOW) && (r_idx == LAST_IDX)
                       && (w_cnt == SHOW_PRE);
        end else begin
            w_fd_nxt = io_scan.i_disp_on && (r_state == BLANK) && (r_idx == LAST_IDX) && w_tc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dig_sel    <= '0;
            r_dec_a      <= '0;
            r_dec_en     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dig_sel    <= w_dig_sel;
            r_dec_a      <= w_dec_a;
            r_dec_en     <= w_dec_en;
            r_frame_done <= w_fd_nxt;
        end
    end

    // The copy reads the pre-write shadow, so a same-cycle write lands only in shadow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else begin
            if (r_frame_done && r_pending) r_display <= r_shadow;
            if (io_scan.i_commit)          r_pending <= 1'b1;
            else if (r_frame_done)         r_pending <= 1'b0;
            if (io_scan.i_wr_en && (int'(io_scan.i_wr_addr) < NUM_DIGITS))
                r_shadow[io_scan.i_wr_addr] <= io_scan.i_wr_data;
        end
    end

    assign io_scan.o_dig_sel    = r_dig_sel;
    assign io_scan.o_dec_a      = r_dec_a;
    assign io_scan.o_dec_en     = r_dec_en;
    assign io_scan.o_frame_done = r_frame_done;
    assign io_scan.o_pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SHOW_CYC=4, BLANK_CYC=2 (24-cycle frame).
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int AW    = 2;
    localparam int SHOWC = 4;
    localparam int BLNKC = 2;
    localparam int SLOT  = SHOWC + BLNKC;
    localparam int FRAME = N * SLOT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(N), .ADDR_W(AW)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS(N), .ADDR_W(AW), .SHOW_CYC(SHOWC), .BLANK_CYC(BLNKC), .CNT_W(16)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .io_scan (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int         cyc;
    logic [3:0] m_shadow [N];
    logic [3:0] m_disp   [N];
    logic       m_pend;
    logic       m_lzb;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_blank(int d);
        if (d == 0) return 1'b0;
        for (int j = d; j < N; j++) if (m_disp[j] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_scan();
        int p, d, w;
        bit show, fd;
        show = 1'b0; fd = 1'b0; d = 0;
        if (cyc > 0) begin
            p    = (cyc - 1) % FRAME;
            d    = p / SLOT;
            w    = p % SLOT;
            show = (w >= BLNKC);
            fd   = (p == FRAME - 1);
        end
        check_val($sformatf("dig_sel@%0d", cyc), bus.o_dig_sel, show ? (32'd1 << d) : 32'd0);
        check_val($sformatf("dec_en@%0d", cyc), bus.o_dec_en, show && !(m_lzb && model_blank(d)));
        if (show) check_val($sformatf("dec_a@%0d", cyc), bus.o_dec_a, m_disp[d]);
        check_val($sformatf("frame_done@%0d", cyc), bus.o_frame_done, fd);
        check_val($sformatf("pending@%0d", cyc), bus.o_pending, m_pend);
    endtask

    // Advance one clock; reference state is updated from the inputs seen at that edge.
    task automatic tick();
        bit fd_now;
        fd_now = (cyc > 0) && (((cyc - 1) % FRAME) == FRAME - 1);
        if (fd_now) begin
            if (m_pend) for (int k = 0; k < N; k++) m_disp[k] = m_shadow[k];
            m_pend = bus.i_commit;
        end else if (bus.i_commit) begin
            m_pend = 1'b1;
        end
        if (bus.i_wr_en) m_shadow[bus.i_wr_addr] = bus.i_wr_data;
        m_lzb = bus.i_lzb_en;
        cyc   = bus.i_disp_on ? cyc + 1 : 0;
        @(posedge clk);
        #1;
        check_scan();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) tick();
        check_val($sformatf("run_to_%0d", target), cyc, target);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic cm);
        bus.i_wr_en = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d; bus.i_commit = cm;
        tick();
        bus.i_wr_en = 1'b0; bus.i_commit = 1'b0;
    endtask

    task automatic model_reset();
        cyc = 0; m_pend = 1'b0;
        for (int k = 0; k < N; k++) begin m_shadow[k] = 4'd0; m_disp[k] = 4'd0; end
    endtask

    initial begin
        bus.i_disp_on = 1'b0; bus.i_lzb_en = 1'b0; bus.i_wr_en = 1'b0;
        bus.i_wr_addr = '0;   bus.i_wr_data = '0;  bus.i_commit = 1'b0;
        m_lzb = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dig_sel", bus.o_dig_sel, 0);
        check_val("rst_dec_en", bus.o_dec_en, 0);
        check_val("rst_dec_a", bus.o_dec_a, 0);
        check_val("rst_frame_done", bus.o_frame_done, 0);
        check_val("rst_pending", bus.o_pending, 0);
        rst = 1'b0;
        tick();

        // Two blank-frame scans
        bus.i_disp_on = 1'b1;
        run_to(48);
        check_val("fd_frame2", bus.o_frame_done, 1);

        // Load 1,2,3,4 and commit mid-frame
        wr(2'd0, 4'd1, 1'b0); wr(2'd1, 4'd2, 1'b0); wr(2'd2, 4'd3, 1'b0); wr(2'd3, 4'd4, 1'b0);
        bus.i_commit = 1'b1; tick(); bus.i_commit = 1'b0;
        check_val("pend_set", bus.o_pending, 1);
        run_to(72);
        check_val("old_disp_d3", bus.o_dec_a, 0);
        run_to(73);
        check_val("pend_clr", bus.o_pending, 0);
        run_to(75); check_val("d0_a", bus.o_dec_a, 1); check_val("d0_sel", bus.o_dig_sel, 4'b0001);
        run_to(81); check_val("d1_a", bus.o_dec_a, 2); check_val("d1_sel", bus.o_dig_sel, 4'b0010);
        run_to(87); check_val("d2_a", bus.o_dec_a, 3); check_val("d2_sel", bus.o_dig_sel, 4'b0100);
        run_to(93); check_val("d3_a", bus.o_dec_a, 4); check_val("d3_sel", bus.o_dig_sel, 4'b1000);

        // Leading-zero blanking on {0,0,5,0}
        bus.i_lzb_en = 1'b1;
        wr(2'd0, 4'd0, 1'b0); wr(2'd1, 4'd5, 1'b0); wr(2'd2, 4'd0, 1'b0); wr(2'd3, 4'd0, 1'b1);
        run_to(123); check_val("lzb_d0_en", bus.o_dec_en, 1); check_val("lzb_d0_a", bus.o_dec_a, 0);
        run_to(129); check_val("lzb_d1_en", bus.o_dec_en, 1); check_val("lzb_d1_a", bus.o_dec_a, 5);
        run_to(135); check_val("lzb_d2_en", bus.o_dec_en, 0); check_val("lzb_d2_sel", bus.o_dig_sel, 4'b0100);
        run_to(141); check_val("lzb_d3_en", bus.o_dec_en, 0); check_val("lzb_d3_sel", bus.o_dig_sel, 4'b1000);

        // Commit + write on the frame-done cycle
        wr(2'd3, 4'd7, 1'b1);
        run_to(144);
        check_val("fd_at_144", bus.o_frame_done, 1);
        wr(2'd0, 4'd9, 1'b1);
        check_val("pend_reset", bus.o_pending, 1);
        run_to(147); check_val("oldshadow_d0", bus.o_dec_a, 0);
        run_to(165); check_val("oldshadow_d3", bus.o_dec_a, 7);
        run_to(169); check_val("pend_done", bus.o_pending, 0);
        run_to(171); check_val("new_d0", bus.o_dec_a, 9);

        // Drop enable during digit 2 show
        run_to(184);
        check_val("pre_drop_sel", bus.o_dig_sel, 4'b0100);
        bus.i_disp_on = 1'b0;
        tick();
        check_val("drop_sel", bus.o_dig_sel, 0);
        check_val("drop_en", bus.o_dec_en, 0);
        check_val("drop_fd", bus.o_frame_done, 0);
        repeat (30) tick();
        bus.i_disp_on = 1'b1;
        tick();
        check_val("restart_blank", bus.o_dig_sel, 0);
        run_to(3);
        check_val("restart_d0", bus.o_dig_sel, 4'b0001);

        // Async reset mid-show
        bus.i_lzb_en = 1'b0;
        bus.i_commit = 1'b1; tick(); bus.i_commit = 1'b0;
        check_val("pre_rst_a", bus.o_dec_a, 9);
        check_val("pre_rst_pend", bus.o_pending, 1);
        #3 rst = 1'b1;
        #1;
        check_val("arst_sel", bus.o_dig_sel, 0);
        check_val("arst_en", bus.o_dec_en, 0);
        check_val("arst_a", bus.o_dec_a, 0);
        check_val("arst_pend", bus.o_pending, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_to(24);
        run_to(27);
        check_val("post_rst_d0_a", bus.o_dec_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
